// File: rtl/mem_arbiter.sv
// Two-port memory arbiter. Fetch (I) and load/store (D) share one memory port,
// with one transaction outstanding, data priority, a fetch anti-starvation streak and a response timeout.
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic [1:0] state;
  logic [3:0] streak_cnt;
  logic [7:0] tmo_cnt;
  logic       pick_d;
  logic       pick_i;
  logic       tmo_hit;

  // D wins unless fetch has waited through STARVE_MAX consecutive D grants.
  always_comb begin
    pick_d  = d_req && (!if_req || (streak_cnt < 4'(STARVE_MAX)));
    pick_i  = !pick_d && if_req;
    tmo_hit = (tmo_cnt == 8'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      streak_cnt <= 4'd0;
      tmo_cnt    <= 8'd0;
      if_gnt     <= 1'b0;
      d_gnt      <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_be     <= 4'd0;
      if_rvalid  <= 1'b0;
      if_rdata   <= 32'd0;
      d_rvalid   <= 1'b0;
      d_rdata    <= 32'd0;
      bus_err    <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      mem_req   <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      bus_err   <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_d) begin
            state     <= BUSY_D;
            d_gnt     <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
            tmo_cnt   <= 8'd0;
            if (!if_req)
              streak_cnt <= 4'd0;
            else if (streak_cnt < 4'(STARVE_MAX))
              streak_cnt <= streak_cnt + 4'd1;
          end else if (pick_i) begin
            state      <= BUSY_I;
            if_gnt     <= 1'b1;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= 32'd0;
            mem_be     <= 4'hF;
            tmo_cnt    <= 8'd0;
            streak_cnt <= 4'd0;
          end
        end

        BUSY_I, BUSY_D: begin
          // A response arriving on the timeout cycle still counts as a normal response.
          if (mem_rvalid) begin
            state <= IDLE;
            if (state == BUSY_I) begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end else begin
              d_rvalid <= 1'b1;
              d_rdata  <= mem_rdata;
            end
          end else if (tmo_hit) begin
            state   <= IDLE;
            bus_err <= 1'b1;
            if (state == BUSY_I) begin
              if_rvalid <= 1'b1;
              if_rdata  <= ERR_DATA;
            end else begin
              d_rvalid <= 1'b1;
              d_rdata  <= ERR_DATA;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory transactions and responses are queued
// when requests are driven and checked as the arbiter grants and responds.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, mem_rvalid;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, bus_err;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  typedef struct {
    bit          port;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mtx_t;

  typedef struct {
    bit          port;
    logic [31:0] data;
    bit          err;
  } rsp_t;

  mtx_t mem_q[$];
  rsp_t resp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 2;
  bit mem_silent = 0;
  int stray_at = -1;
  int last_mrv = -10;
  int last_d_rv = -10;
  int gd, gi, g;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : {a[15:0], ~a[15:0]};
  endfunction

  task automatic push_m(input bit port, input logic [31:0] addr, input bit we,
                        input logic [31:0] wdata, input logic [3:0] be);
    mtx_t m;
    m.port = port; m.addr = addr; m.we = we; m.wdata = wdata; m.be = be;
    mem_q.push_back(m);
  endtask

  task automatic push_r(input bit port, input logic [31:0] data, input bit err);
    rsp_t r;
    r.port = port; r.data = data; r.err = err;
    resp_q.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit port, output int gcyc);
    gcyc = -1;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (port ? d_gnt : if_gnt) begin
        gcyc = cyc;
        return;
      end
    end
    chk(port ? "d_gnt_wait" : "if_gnt_wait", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100 && resp_q.size() != 0; n++)
      tick();
    chk("drain", resp_q.size(), 0);
    @(negedge clk);
  endtask

  // Memory model: answers each mem_req after mem_lat cycles unless silenced.
  initial begin
    bit          pend;
    int          cnt;
    logic [31:0] paddr;
    pend = 0; cnt = 0; paddr = 0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (!rst) begin
        pend = 0;
      end else begin
        if (cyc == stray_at) begin
          mem_rvalid = 1'b1;
          mem_rdata  = 32'h1234_5678;
        end else if (pend) begin
          if (cnt <= 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_model(paddr);
            pend = 0;
            last_mrv = cyc;
          end else begin
            cnt--;
          end
        end
        if (mem_req && !mem_silent) begin
          if (mem_lat == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_model(mem_addr);
            last_mrv = cyc;
          end else begin
            pend = 1; cnt = mem_lat; paddr = mem_addr;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every grant and every response.
  initial forever begin
    mtx_t m;
    rsp_t r;
    @(negedge clk);
    if (rst) begin
      if (if_gnt && d_gnt) chk("dual_gnt", 32'd1, 32'd0);
      if (if_rvalid && d_rvalid) chk("dual_rvalid", 32'd1, 32'd0);
      if (if_gnt || d_gnt || mem_req) begin
        chk("memreq_with_gnt", mem_req, if_gnt | d_gnt);
        if (mem_q.size() == 0) begin
          chk("unexpected_gnt", 32'd1, 32'd0);
        end else begin
          m = mem_q.pop_front();
          chk("gnt_port", d_gnt, m.port);
          chk("mem_addr", mem_addr, m.addr);
          chk("mem_we", mem_we, m.we);
          chk("mem_wdata", mem_wdata, m.wdata);
          chk("mem_be", mem_be, m.be);
        end
      end
      if (if_rvalid || d_rvalid || bus_err) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          r = resp_q.pop_front();
          chk("rsp_port", d_rvalid, r.port);
          chk("rsp_data", r.port ? d_rdata : if_rdata, r.data);
          chk("rsp_bus_err", bus_err, r.err);
          if (!r.err) chk("rsp_latency", cyc, last_mrv + 1);
        end
        if (d_rvalid) last_d_rv = cyc;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", |{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_req, mem_we,
                           mem_addr, mem_wdata, mem_be, bus_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single fetch, memory latency 2
    mem_lat = 2;
    if_req = 1; if_addr = 32'h100;
    push_m(0, 32'h100, 0, 32'd0, 4'hF);
    push_r(0, 32'h0050_0093, 0);
    tick();
    chk("fetch_gnt_c1", if_gnt, 1);
    chk("fetch_memreq_c1", mem_req, 1);
    chk("fetch_addr_c1", mem_addr, 32'h100);
    chk("fetch_d_gnt_c1", d_gnt, 0);
    if_req = 0;
    tick(); tick();
    chk("fetch_rvalid_c3", if_rvalid, 0);
    tick();
    chk("fetch_rvalid_c4", if_rvalid, 1);
    chk("fetch_rdata_c4", if_rdata, 32'h0050_0093);
    chk("fetch_d_rvalid_c4", d_rvalid, 0);
    chk("fetch_d_rdata_c4", d_rdata, 0);
    wait_drain();

    // Store
    mem_lat = 3;
    d_req = 1; d_we = 1; d_addr = 32'h2004; d_wdata = 32'hCAFE_F00D; d_be = 4'b0011;
    push_m(1, 32'h2004, 1, 32'hCAFE_F00D, 4'b0011);
    push_r(1, mem_model(32'h2004), 0);
    wait_gnt(1, gd);
    chk("store_memreq", mem_req, 1);
    d_req = 0; d_we = 0;
    tick();
    chk("store_memreq_pulse", mem_req, 0);
    chk("store_addr_held", mem_addr, 32'h2004);
    wait_drain();

    // Simultaneous requests: D first, I right after d_rvalid
    mem_lat = 1;
    d_req = 1; d_addr = 32'h40; d_wdata = 32'd0; d_be = 4'hF;
    if_req = 1; if_addr = 32'h80;
    push_m(1, 32'h40, 0, 32'd0, 4'hF);
    push_m(0, 32'h80, 0, 32'd0, 4'hF);
    push_r(1, mem_model(32'h40), 0);
    push_r(0, mem_model(32'h80), 0);
    fork
      begin wait_gnt(1, gd); d_req = 0; end
      begin wait_gnt(0, gi); if_req = 0; end
    join
    chk("sim_d_first", (gd < gi), 1);
    chk("sim_i_after_drv", gi, last_d_rv + 1);
    wait_drain();

    // Starvation: both held, expect D,D,D,D,I,D
    mem_lat = 0;
    begin
      bit exp_port[6] = '{1, 1, 1, 1, 0, 1};
      int dn = 0;
      for (int k = 0; k < 6; k++) begin
        if (exp_port[k]) begin
          push_m(1, 32'h1000 + 32'(dn * 4), 0, 32'd0, 4'hF);
          push_r(1, mem_model(32'h1000 + 32'(dn * 4)), 0);
          dn++;
        end else begin
          push_m(0, 32'h500, 0, 32'd0, 4'hF);
          push_r(0, mem_model(32'h500), 0);
        end
      end
      dn = 0;
      d_req = 1; d_we = 0; d_addr = 32'h1000; if_req = 1; if_addr = 32'h500;
      for (int k = 0; k < 6; k++) begin
        bit got;
        got = 0;
        for (int n = 0; n < 30 && !got; n++) begin
          tick();
          got = if_gnt || d_gnt;
        end
        chk("starve_gnt_seen", got, 1);
        chk("starve_order", d_gnt, exp_port[k]);
        if (if_gnt) chk("streak_after_i", dut.streak_cnt, 0);
        if (d_gnt) begin
          dn++;
          d_addr = 32'h1000 + 32'(dn * 4);
        end
      end
      d_req = 0; if_req = 0;
    end
    wait_drain();

    // Timeout on a fetch, then a stray response
    mem_silent = 1;
    if_req = 1; if_addr = 32'h300;
    push_m(0, 32'h300, 0, 32'd0, 4'hF);
    push_r(0, 32'hDEAD_BEEF, 1);
    wait_gnt(0, g);
    if_req = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      if (k == TIMEOUT - 1) chk("tmo_early", if_rvalid, 0);
    end
    chk("tmo_rvalid", if_rvalid, 1);
    chk("tmo_rdata", if_rdata, 32'hDEAD_BEEF);
    chk("tmo_bus_err", bus_err, 1);
    stray_at = cyc + 2;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stray_no_rsp", {if_rvalid, d_rvalid, bus_err}, 0);
    end
    mem_silent = 0;
    @(negedge clk);

    // Reset while a load is outstanding
    mem_silent = 1;
    d_req = 1; d_we = 0; d_addr = 32'h2400; d_be = 4'hF;
    push_m(1, 32'h2400, 0, 32'd0, 4'hF);
    wait_gnt(1, gd);
    d_req = 0;
    tick();
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_outs", |{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_req, mem_we,
                            mem_addr, mem_wdata, mem_be, bus_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    mem_silent = 0;
    chk("rst_state_idle", 32'(dut.state), 0);
    mem_lat = 2;
    if_req = 1; if_addr = 32'h180;
    push_m(0, 32'h180, 0, 32'd0, 4'hF);
    push_r(0, mem_model(32'h180), 0);
    wait_gnt(0, gi);
    if_req = 0;
    wait_drain();
    repeat (4) begin
      tick();
      chk("post_rst_no_d_rvalid", d_rvalid, 0);
    end

    chk("mem_q_empty", mem_q.size(), 0);
    chk("resp_q_empty", resp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
